// File: rtl/gray_cnt_pkg.sv
// rtl/gray_cnt_pkg.sv - shared width, Gray word type and Gray helpers for gray_decade_counter
package gray_cnt_pkg;

  localparam int GRAY_W = 4;

  typedef logic [GRAY_W-1:0] gray_t;

  function automatic gray_t bin2gray(input gray_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] popcount4(input gray_t v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - sticky flag for a qualified counting step that is not a single Gray bit flip
module gray_step_checker
  import gray_cnt_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  gray_t i_gray_prev,
  input  gray_t i_gray_next,
  input  logic  i_check,
  output logic  o_step_err
);

  logic w_bad_step;

  assign w_bad_step = i_check && (popcount4(i_gray_prev ^ i_gray_next) != 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_step_err <= 1'b0;
    end else if (w_bad_step) begin
      o_step_err <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_decade_counter.sv
// rtl/gray_decade_counter.sv - up/down mod-(MAX+1) counter with registered Gray output, load and cascade carry
// Optional GRAY_CNT_STEP_CHECK_EN adds the sticky step_err output.
module gray_decade_counter
  import gray_cnt_pkg::*;
#(
  parameter int MAX       = 9,
  parameter int RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] gray_q,
  output logic [3:0] bin_q,
  output logic       tc,
  output logic       co,
  output logic       chg,
`ifdef GRAY_CNT_STEP_CHECK_EN
  output logic       step_err,
`endif
  output logic       load_err
);

  localparam gray_t MAX_V = gray_t'(MAX);
  localparam gray_t RST_V = gray_t'(RESET_VAL);

  gray_t r_bin;
  gray_t r_gray;
  logic  r_chg;
  logic  r_load_err;

  gray_t w_bin_nxt;
  gray_t w_gray_nxt;
  logic  w_load_ok;
  logic  w_load_bad;
  logic  w_at_max;
  logic  w_at_zero;

  assign w_load_ok  = load && (load_val <= MAX_V);
  assign w_load_bad = load && (load_val > MAX_V);
  assign w_at_max   = (r_bin == MAX_V);
  assign w_at_zero  = (r_bin == '0);

  // Combinational so a ripple cascade advances on the same edge as this stage.
  assign tc = dir ? w_at_max : w_at_zero;
  assign co = en & tc;

  always_comb begin
    w_bin_nxt = r_bin;
    if (load) begin
      if (w_load_ok) begin
        w_bin_nxt = load_val;
      end
    end else if (en) begin
      if (dir) begin
        w_bin_nxt = w_at_max ? '0 : r_bin + 4'd1;
      end else begin
        w_bin_nxt = w_at_zero ? MAX_V : r_bin - 4'd1;
      end
    end
  end

  assign w_gray_nxt = bin2gray(w_bin_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= RST_V;
      r_gray     <= bin2gray(RST_V);
      r_chg      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_bin      <= w_bin_nxt;
      r_gray     <= w_gray_nxt;
      r_chg      <= (w_gray_nxt != r_gray);
      r_load_err <= w_load_bad;
    end
  end

  assign bin_q    = r_bin;
  assign gray_q   = r_gray;
  assign chg      = r_chg;
  assign load_err = r_load_err;

`ifdef GRAY_CNT_STEP_CHECK_EN
  // Only plain counting edges are checked; loads and wraps may flip several bits.
  logic w_step_check;

  assign w_step_check = en & ~load & ~tc;

  gray_step_checker u_step_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_gray_prev (r_gray),
    .i_gray_next (w_gray_nxt),
    .i_check     (w_step_check),
    .o_step_err  (step_err)
  );
`endif

endmodule

// File: tb/tb_gray_decade_counter.sv
// tb/tb_gray_decade_counter.sv - directed self-checking bench for gray_decade_counter
module tb_gray_decade_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] gray_q;
  logic [3:0] bin_q;
  logic       tc;
  logic       co;
  logic       chg;
  logic       load_err;
`ifdef GRAY_CNT_STEP_CHECK_EN
  logic       step_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] gray_tab [10];

  gray_decade_counter #(.MAX(9), .RESET_VAL(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .gray_q   (gray_q),
    .bin_q    (bin_q),
    .tc       (tc),
    .co       (co),
    .chg      (chg),
`ifdef GRAY_CNT_STEP_CHECK_EN
    .step_err (step_err),
`endif
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] b, input logic c, input logic le);
    check({tag, " bin"}, bin_q, b);
    check({tag, " gray"}, gray_q, gray_tab[b]);
    check({tag, " chg"}, {3'b0, chg}, {3'b0, c});
    check({tag, " load_err"}, {3'b0, load_err}, {3'b0, le});
  endtask

  initial begin
    gray_tab[0] = 4'b0000; gray_tab[1] = 4'b0001; gray_tab[2] = 4'b0011;
    gray_tab[3] = 4'b0010; gray_tab[4] = 4'b0110; gray_tab[5] = 4'b0111;
    gray_tab[6] = 4'b0101; gray_tab[7] = 4'b0100; gray_tab[8] = 4'b1100;
    gray_tab[9] = 4'b1101;

    rst_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0;
    #12;
    check_state("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up count through a full wrap: 12 edges
    en = 1'b1; dir = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      check("up co", {3'b0, co}, {3'b0, (i % 10) == 9});
      tick();
      check_state("up step", 4'((i + 1) % 10), 1'b1, 1'b0);
    end

    // Load 0 then count down across the wrap
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick();
    check_state("load0", 4'd0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    #1;
    check("down tc at 0", {3'b0, tc}, 4'd1);
    check("down co at 0", {3'b0, co}, 4'd1);
    tick();
    check_state("down wrap", 4'd9, 1'b1, 1'b0);
    check("down gray 9", gray_q, 4'b1101);
    check("down co at 9", {3'b0, co}, 4'd0);
    tick();
    check_state("down 8", 4'd8, 1'b1, 1'b0);
    check("down gray 8", gray_q, 4'b1100);
    tick();
    check_state("down 7", 4'd7, 1'b1, 1'b0);
    check("down gray 7", gray_q, 4'b0100);

    // Load beats en
    dir = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    check_state("load3", 4'd3, 1'b1, 1'b0);
    load_val = 4'd7;
    tick();
    check_state("load7 en", 4'd7, 1'b1, 1'b0);
    tick();
    check_state("reload7", 4'd7, 1'b0, 1'b0);

    // Rejected loads
    load_val = 4'd12;
    tick();
    check_state("load12", 4'd7, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    tick();
    check_state("after load12", 4'd7, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd10;
    tick();
    check_state("load10", 4'd7, 1'b0, 1'b1);
    load_val = 4'd9;
    tick();
    check_state("load9", 4'd9, 1'b1, 1'b0);
    load = 1'b0;
    #1;
    check("tc up at 9 en0", {3'b0, tc}, 4'd1);
    check("co en0", {3'b0, co}, 4'd0);
    dir = 1'b0;
    #1;
    check("tc down at 9", {3'b0, tc}, 4'd0);
    tick();
    check_state("hold", 4'd9, 1'b0, 1'b0);

    // Async reset mid-count
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_state("count5", 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_state("resume", 4'd1, 1'b1, 1'b0);

`ifdef GRAY_CNT_STEP_CHECK_EN
    check("step_err", {3'b0, step_err}, 4'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
